// File: rtl/data_mem_sw_if.sv
// data_mem_sw_if: store request/handshake and word-memory port bundle for data_mem_sw
interface data_mem_sw_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  Store_Req;
    logic [2:0]            Lw_Sw_OP;
    logic [ADDR_WIDTH-1:0] Store_Addr;
    logic [31:0]           Store_Data;
    logic                  Store_Ready;
    logic                  Store_Done;
    logic [ADDR_WIDTH-3:0] Mem_Addr;
    logic                  Mem_Rd_En;
    logic [31:0]           Mem_Rd_Data;
    logic                  Mem_Wr_En;
    logic [31:0]           Mem_Wr_Data;
    logic                  Misalign_Err;
    modport master (
        output Store_Req, Lw_Sw_OP, Store_Addr, Store_Data, Mem_Rd_Data,
        input  Store_Ready, Store_Done, Mem_Addr, Mem_Rd_En, Mem_Wr_En, Mem_Wr_Data, Misalign_Err
    );
    modport slave (
        input  Store_Req, Lw_Sw_OP, Store_Addr, Store_Data, Mem_Rd_Data,
        output Store_Ready, Store_Done, Mem_Addr, Mem_Rd_En, Mem_Wr_En, Mem_Wr_Data, Misalign_Err
    );
endinterface

// File: rtl/data_mem_sw.sv
// data_mem_sw: SB/SH/SW store unit over a word-only memory (read-modify-write for SB/SH); STORE_MISALIGN_TRAP_EN enables misalignment trapping
module data_mem_sw #(
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input logic          Clk,
    input logic          Reset,
    data_mem_sw_if.slave bus
);
    localparam logic [2:0] SB_OP_STORE = 3'b000;
    localparam logic [2:0] SH_OP_STORE = 3'b001;
    localparam logic [2:0] SW_OP_STORE = 3'b010;
    typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;
    state_t                state, state_nxt;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [31:0]           merge_q;
    logic [31:0]           wr_word;
    logic [2:0]            cnt;
    logic                  accept;
    logic                  op_ok;
    logic                  mis;
    logic                  last;
    assign accept = bus.Store_Req && state == IDLE;
    assign op_ok  = bus.Lw_Sw_OP inside {SB_OP_STORE, SH_OP_STORE, SW_OP_STORE};
    assign last   = cnt == 3'(READ_LATENCY - 1);
`ifdef STORE_MISALIGN_TRAP_EN
    logic err_q;
    assign mis = (bus.Lw_Sw_OP == SH_OP_STORE && bus.Store_Addr[0]) ||
                 (bus.Lw_Sw_OP == SW_OP_STORE && bus.Store_Addr[1:0] != 2'b00);
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) err_q <= 1'b0;
        else       err_q <= accept && mis;
    assign bus.Misalign_Err = err_q;
`else
    assign mis              = 1'b0;
    assign bus.Misalign_Err = 1'b0;
`endif
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && op_ok && !mis) state_nxt = (bus.Lw_Sw_OP == SW_OP_STORE) ? WRITE : READ;
            READ:    state_nxt = WAIT;
            WAIT:    if (last) state_nxt = WRITE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            merge_q <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus.Lw_Sw_OP;
                addr_q <= bus.Store_Addr;
                data_q <= bus.Store_Data;
            end
            cnt <= (state == WAIT) ? cnt + 3'd1 : 3'd0;
            if (state == WAIT && last) merge_q <= bus.Mem_Rd_Data;
        end
    // Lane merge depends only on registered request and the captured read word.
    always_comb begin
        wr_word = merge_q;
        if (op_q == SB_OP_STORE)      wr_word[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else if (op_q == SH_OP_STORE) wr_word[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
        else                          wr_word = data_q;
    end
    assign bus.Store_Ready = state == IDLE;
    assign bus.Mem_Rd_En   = state == READ;
    assign bus.Mem_Wr_En   = state == WRITE;
    assign bus.Store_Done  = state == WRITE;
    assign bus.Mem_Addr    = addr_q[ADDR_WIDTH-1:2];
    assign bus.Mem_Wr_Data = wr_word;
endmodule

// File: tb/tb_data_mem_sw.sv
// tb_data_mem_sw: directed vector table plus back-to-back and mid-operation reset sequences for data_mem_sw
module tb_data_mem_sw;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_sw_if #(.ADDR_WIDTH(32)) b0 ();
    data_mem_sw_if #(.ADDR_WIDTH(32)) b1 ();
    data_mem_sw #(.ADDR_WIDTH(32), .READ_LATENCY(1)) u0 (.Clk(clk), .Reset(rst), .bus(b0));
    data_mem_sw #(.ADDR_WIDTH(32), .READ_LATENCY(3)) u1 (.Clk(clk), .Reset(rst), .bus(b1));

    // Memory models: read data valid READ_LATENCY cycles after the strobe, garbage otherwise.
    logic [31:0] mem [0:255];
    logic        v0  = 1'b0;
    logic [7:0]  ra0 = '0;
    logic [2:0]  v1  = '0;
    always @(posedge clk) begin
        v0  <= b0.Mem_Rd_En;
        ra0 <= b0.Mem_Addr[7:0];
        v1  <= {v1[1:0], b1.Mem_Rd_En};
    end
    assign b0.Mem_Rd_Data = v0 ? mem[ra0] : 32'hBAD0BAD0;
    assign b1.Mem_Rd_Data = v1[2] ? 32'h11223344 : 32'hBAD0BAD0;

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mem;
        int          wr_cyc;
        logic [31:0] wr;
        int          rd_cyc;
        int          rdy_cyc;
        int          err_cyc;
    } vec_t;

    function automatic vec_t mk(string nm, logic [2:0] op, logic [31:0] a, logic [31:0] d, logic [31:0] m,
                                int wc, logic [31:0] w, int rc, int ry, int ec);
        vec_t v;
        v.name = nm; v.op = op; v.addr = a; v.data = d; v.mem = m;
        v.wr_cyc = wc; v.wr = w; v.rd_cyc = rc; v.rdy_cyc = ry; v.err_cyc = ec;
        return v;
    endfunction

    localparam int NV = 12;
    vec_t vt [NV];

    initial begin
        int rd_c, wr_c, rdy_c, err_c, n_wr;
        logic [31:0] wr_d, wr_a;
        logic done_bad;
        logic [15:0] acc_m, wr_m, rd_m;

        vt[0]  = mk("sw",     3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        1, 32'hDEADBEEF, 0, 2, 0);
        vt[1]  = mk("sb2",    3'b000, 32'h102, 32'h000000AB, 32'h11223344, 3, 32'h11AB3344, 1, 4, 0);
        vt[2]  = mk("sh1",    3'b001, 32'h102, 32'hFFFFCAFE, 32'h11223344, 3, 32'hCAFE3344, 1, 4, 0);
        vt[3]  = mk("sb0",    3'b000, 32'h200, 32'h00000055, 32'hAABBCCDD, 3, 32'hAABBCC55, 1, 4, 0);
        vt[4]  = mk("sb3",    3'b000, 32'h203, 32'h12345677, 32'hAABBCCDD, 3, 32'h77BBCCDD, 1, 4, 0);
        vt[5]  = mk("sb1",    3'b000, 32'h201, 32'h000000EE, 32'h01020304, 3, 32'h0102EE04, 1, 4, 0);
        vt[6]  = mk("sh0",    3'b001, 32'h100, 32'h1234BEEF, 32'h11223344, 3, 32'h1122BEEF, 1, 4, 0);
`ifdef STORE_MISALIGN_TRAP_EN
        vt[7]  = mk("sh_mis", 3'b001, 32'h101, 32'h0000BEEF, 32'h11223344, 0, 32'h0,        0, 1, 1);
        vt[8]  = mk("sw_mis", 3'b010, 32'h10E, 32'h01234567, 32'h0,        0, 32'h0,        0, 1, 1);
`else
        vt[7]  = mk("sh_mis", 3'b001, 32'h101, 32'h0000BEEF, 32'h11223344, 3, 32'h1122BEEF, 1, 4, 0);
        vt[8]  = mk("sw_mis", 3'b010, 32'h10E, 32'h01234567, 32'h0,        1, 32'h01234567, 0, 2, 0);
`endif
        vt[9]  = mk("bad3",   3'b011, 32'h104, 32'h12345678, 32'h0,        0, 32'h0,        0, 1, 0);
        vt[10] = mk("bad7",   3'b111, 32'h108, 32'h12345678, 32'h0,        0, 32'h0,        0, 1, 0);
        vt[11] = mk("sb_odd", 3'b000, 32'h103, 32'h000000C3, 32'h11223344, 3, 32'hC3223344, 1, 4, 0);

        for (int i = 0; i < 256; i++) mem[i] = '0;
        b0.Store_Req = 1'b0; b0.Lw_Sw_OP = 3'b000; b0.Store_Addr = '0; b0.Store_Data = '0;
        b1.Store_Req = 1'b0; b1.Lw_Sw_OP = 3'b000; b1.Store_Addr = '0; b1.Store_Data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst ready", b0.Store_Ready, 1);
        chk("rst rd_en", b0.Mem_Rd_En, 0);
        chk("rst wr_en", b0.Mem_Wr_En, 0);
        chk("rst done", b0.Store_Done, 0);
        chk("rst addr", b0.Mem_Addr, 0);
        chk("rst wdata", b0.Mem_Wr_Data, 0);
        chk("rst err", b0.Misalign_Err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table on the READ_LATENCY=1 instance
        for (int i = 0; i < NV; i++) begin
            mem[vt[i].addr[9:2]] = vt[i].mem;
            chk({vt[i].name, " ready0"}, b0.Store_Ready, 1);
            b0.Store_Req = 1'b1; b0.Lw_Sw_OP = vt[i].op; b0.Store_Addr = vt[i].addr; b0.Store_Data = vt[i].data;
            rd_c = 0; wr_c = 0; rdy_c = 0; err_c = 0; n_wr = 0; wr_d = '0; wr_a = '0; done_bad = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    b0.Store_Req = 1'b0; b0.Lw_Sw_OP = 3'b111; b0.Store_Addr = $urandom; b0.Store_Data = $urandom;
                end
                if (b0.Mem_Rd_En && rd_c == 0) rd_c = c;
                if (b0.Mem_Wr_En) begin
                    n_wr++;
                    if (wr_c == 0) begin wr_c = c; wr_d = b0.Mem_Wr_Data; wr_a = 32'(b0.Mem_Addr); end
                end
                if (b0.Store_Done !== b0.Mem_Wr_En) done_bad = 1'b1;
                if (b0.Misalign_Err && err_c == 0) err_c = c;
                if (b0.Store_Ready && rdy_c == 0) rdy_c = c;
            end
            chk({vt[i].name, " wr_cyc"}, wr_c, vt[i].wr_cyc);
            chk({vt[i].name, " n_wr"}, n_wr, (vt[i].wr_cyc != 0) ? 1 : 0);
            chk({vt[i].name, " rd_cyc"}, rd_c, vt[i].rd_cyc);
            chk({vt[i].name, " rdy_cyc"}, rdy_c, vt[i].rdy_cyc);
            chk({vt[i].name, " err_cyc"}, err_c, vt[i].err_cyc);
            chk({vt[i].name, " done_sync"}, done_bad, 0);
            if (wr_c != 0) begin
                chk({vt[i].name, " wdata"}, wr_d, vt[i].wr);
                chk({vt[i].name, " waddr"}, wr_a, {2'b00, vt[i].addr[31:2]});
            end
        end

        // Back-to-back SBs on the READ_LATENCY=3 instance, request held high
        b1.Store_Req = 1'b1; b1.Lw_Sw_OP = 3'b000; b1.Store_Addr = 32'h12; b1.Store_Data = 32'hAB;
        acc_m = '0; wr_m = '0; rd_m = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (b1.Store_Ready && b1.Store_Req) acc_m[c] = 1'b1;
            if (b1.Mem_Rd_En) rd_m[c] = 1'b1;
            if (b1.Mem_Wr_En) begin
                wr_m[c] = 1'b1;
                chk("b2b wdata", b1.Mem_Wr_Data, 32'h11AB3344);
                chk("b2b waddr", b1.Mem_Addr, 32'h4);
                chk("b2b done", b1.Store_Done, 1);
            end
            if (c == 7) b1.Store_Req = 1'b0;
        end
        chk("b2b accept mask", acc_m, 16'h0040);
        chk("b2b write mask", wr_m, 16'h0820);
        chk("b2b read mask", rd_m, 16'h0082);

        // Reset asserted while an SB waits for read data
        b1.Store_Req = 1'b1; b1.Lw_Sw_OP = 3'b000; b1.Store_Addr = 32'h12; b1.Store_Data = 32'hAB;
        wr_m = '0; rd_m = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) b1.Store_Req = 1'b0;
            if (c == 3) begin
                rst = 1'b1;
                #1;
                chk("rstmid ready", b1.Store_Ready, 1);
            end
            if (c == 5) rst = 1'b0;
            if (b1.Mem_Rd_En) rd_m[c] = 1'b1;
            if (b1.Mem_Wr_En) wr_m[c] = 1'b1;
        end
        chk("rstmid write mask", wr_m, 16'h0000);
        chk("rstmid read mask", rd_m, 16'h0002);
        chk("rstmid ready", b1.Store_Ready, 1);
        chk("rstmid rd_en", b1.Mem_Rd_En, 0);
        chk("rstmid done", b1.Store_Done, 0);
        chk("rstmid addr", b1.Mem_Addr, 0);
        chk("rstmid wdata", b1.Mem_Wr_Data, 0);
        chk("rstmid err", b1.Misalign_Err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_sw.md
Name: data_mem_sw

Overview:
- Store-side companion to the load-extraction path: executes SB/SH/SW against a data memory that has only whole-word writes and no byte enables.
- SW is written directly.
- SB/SH use a read-modify-write sequence: read the word, merge the byte/halfword lane, write the word back.
- Sits between the execute stage and the data memory port; it holds the core off via Store_Ready while a store is in flight.

Parameters:
- ADDR_WIDTH, 32, byte-address width of Store_Addr.
- READ_LATENCY, 1, cycles from Mem_Rd_En to valid Mem_Rd_Data (legal 1..4).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Store_Req  input  1  store request; accepted when Store_Req && Store_Ready.
- Lw_Sw_OP  input  3  store op: `SB_OP_STORE`=3'b000, `SH_OP_STORE`=3'b001, `SW_OP_STORE`=3'b010 (define.vh, equal to RISC-V funct3).
- Store_Addr  input  ADDR_WIDTH  byte address.
- Store_Data  input  32  rs2 value; the low byte/halfword is used for SB/SH.
- Store_Ready  output  1  high only in IDLE.
- Store_Done  output  1  one-cycle pulse, coincident with Mem_Wr_En.
- Mem_Addr  output  ADDR_WIDTH-2  word address (latched Store_Addr[ADDR_WIDTH-1:2]).
- Mem_Rd_En  output  1  one-cycle word read strobe.
- Mem_Rd_Data  input  32  read data, valid READ_LATENCY cycles after Mem_Rd_En.
- Mem_Wr_En  output  1  one-cycle word write strobe.
- Mem_Wr_Data  output  32  merged write word.
- Misalign_Err  output  1  one-cycle misalignment pulse (optional feature only).

Behaviour:
- Reset values: state IDLE, Store_Ready=1, Store_Done=0, Mem_Rd_En=0, Mem_Wr_En=0, Mem_Addr=0, Mem_Wr_Data=0, Misalign_Err=0. Latched op/addr/data and merge register cleared.
- On acceptance, Lw_Sw_OP, Store_Addr and Store_Data are registered. The inputs are don't-care afterwards.
- Memory outputs are decoded from the state and the registered request only. There is no combinational input-to-output path.

States:
- IDLE: on accept, go to WRITE for SW, or READ for SB/SH. An invalid op is accepted and dropped: stay in IDLE, no access, no Done.
- READ: Mem_Rd_En=1 for exactly one cycle, then go to WAIT.
- WAIT: a counter runs READ_LATENCY cycles. On the last WAIT cycle, capture Mem_Rd_Data into the merge register, then go to WRITE.
- WRITE: Mem_Wr_En=1 and Store_Done=1 for one cycle, then go to IDLE.

Latency (accept at cycle 0):
- SW: write at cycle 1, Store_Ready high at cycle 2.
- SB/SH: READ at 1, WAIT at 2..1+READ_LATENCY, WRITE at 2+READ_LATENCY, Store_Ready high one cycle later.

Merge rules:
- SB: byte lane Addr[1:0] ← Store_Data[7:0]; the other three lanes keep the read word.
- SH: halfword lane Addr[1] (0 → bits 15:0, 1 → bits 31:16) ← Store_Data[15:0]; the other half keeps the read word.
- SW: Mem_Wr_Data = Store_Data.

Other rules:
- Back-to-back requests: Store_Req held high is accepted again on the first cycle Store_Ready returns. No bubble beyond that cycle.
- Reset asserted mid-operation: immediate return to IDLE. Any pending write is aborted (no Mem_Wr_En) and captured data is discarded.
- Mem_Rd_Data is ignored outside the capture cycle.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined:
  - SH with Addr[0]=1, or SW with Addr[1:0]≠0, is accepted but causes no memory access and no Store_Done.
  - Misalign_Err pulses the cycle after acceptance; the FSM stays in IDLE.
  - SB never traps.
- Undefined:
  - Misalign_Err is tied to 0.
  - SH ignores Addr[0]; SW ignores Addr[1:0]. Both proceed as aligned.

Test Plan:
- SW 0xDEADBEEF to addr 0x104 → cycle 1: Mem_Wr_En=1, Mem_Addr=0x41, Mem_Wr_Data=0xDEADBEEF, Store_Done=1; Mem_Rd_En never asserted.
- Memory word 0x11223344, SB Store_Data=0x000000AB, addr 0x102, READ_LATENCY=1 → Mem_Rd_En at cycle 1; Mem_Wr_En at cycle 3 with data 0x11AB3344.
- Memory word 0x11223344, SH Store_Data=0xFFFFCAFE, addr 0x102 → Mem_Wr_Data=0xCAFE3344.
- With READ_LATENCY=3: Store_Req held high for two SBs → second accept one cycle after the first Store_Done; each write lands at accept+5.
- Reset asserted in WAIT of an SB → no Mem_Wr_En ever; after release Store_Ready=1 and all outputs at reset values.
- SH to addr 0x101:
  - With STORE_MISALIGN_TRAP_EN: Misalign_Err pulses at cycle 1; no read or write.
  - Without it: behaves as SH to 0x100.
